// File: rtl/mod_accel_seq.sv
// mod_accel_seq: sequential modular-arithmetic accelerator.
//   Operations on W-bit operands modulo n: ADD, SUB, MOD ({a,b} mod n),
//   RSET (computes and stores R2 = 2^(2W) mod n), MUL (Montgomery a*b mod n)
//   and EXP (a^b mod n, MSB-first square-and-multiply in Montgomery form).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, control      request and opcode, sampled only while busy=0
//   a, b, modulant      operands and modulus n, latched with the request
//   result              result of the last error-free completed operation
//   finished, err       one-cycle completion pulse and its error qualifier
//   busy                operation in progress
//   r_valid             stored R2 is valid for the stored modulus n_r
module mod_accel_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            control,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  finished,
  output logic                  busy,
  output logic                  err,
  output logic                  r_valid
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(2*W+1);
  localparam int KW = $clog2(W);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOD  = 3'b010;
  localparam logic [2:0] OP_RSET = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_EXP  = 3'b101;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDSUB = 3'd1;
  localparam logic [2:0] S_MODRED = 3'd2;
  localparam logic [2:0] S_RSETUP = 3'd3;
  localparam logic [2:0] S_MONT   = 3'd4;
  localparam logic [2:0] S_EXPSEQ = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // Which Montgomery product the sequencer is currently waiting on
  localparam logic [2:0] PH_MUL1 = 3'd0;
  localparam logic [2:0] PH_MUL2 = 3'd1;
  localparam logic [2:0] PH_ABAR = 3'd2;
  localparam logic [2:0] PH_ACC  = 3'd3;
  localparam logic [2:0] PH_SQ   = 3'd4;
  localparam logic [2:0] PH_MULB = 3'd5;
  localparam logic [2:0] PH_FIN  = 3'd6;

  localparam logic [CW-1:0] CNT_MONT_LAST = CW'(W-1);
  localparam logic [CW-1:0] CNT_RED_LAST  = CW'(2*W);
  localparam logic [W-1:0]  ONE           = {{(W-1){1'b0}}, 1'b1};

  // One conditional subtract; caller guarantees v < 2n (or v-n fits W bits)
  function automatic logic [W-1:0] red1(input logic [W+1:0] v, input logic [W-1:0] n);
    return (v >= {2'b00, n}) ? W'(v - {2'b00, n}) : W'(v);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] n);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + {1'b0, n};
    return W'(d);
  endfunction

  // Radix-2 Montgomery iteration: t = (t + xb*y + q*n) / 2, q makes the sum even
  function automatic logic [W+1:0] mont_step(input logic [W+1:0] t, input logic xb,
                                             input logic [W-1:0] y, input logic [W-1:0] n);
    logic [W+1:0] s;
    s = t + (xb ? {2'b00, y} : '0);
    if (s[0]) s = s + {2'b00, n};
    return s >> 1;
  endfunction

  logic [2:0]    state_q, ph_q, nx_ph, op_q;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] k_q, nx_k;
  logic          seq_init_q, err_q, lat_err, seq_done, accept;
  logic [W-1:0]  r2_q, n_r_q;
  logic [W-1:0]  a_q, b_q, n_q, acc_q, x_q, y_q, abar_q, res_q, mm_res, nx_x, nx_y;
  logic [2*W-1:0] sr_q;
  logic [W+1:0]  t_q;

  assign accept = start && !busy;
  assign mm_res = red1(t_q, n_q);

  always_comb begin
    lat_err = 1'b0;
    case (control)
      OP_ADD, OP_SUB: lat_err = (a >= modulant) || (b >= modulant);
      OP_MOD:         lat_err = 1'b0;
      OP_RSET:        lat_err = !modulant[0];
      OP_MUL, OP_EXP: lat_err = !modulant[0] || !r_valid || (modulant != n_r_q);
      default:        lat_err = 1'b1;
    endcase
    if (modulant == '0) lat_err = 1'b1;
  end

  // Sequencer: on each finished product, pick the operands of the next one.
  // The final subtract and this decision share one cycle, so each product
  // costs exactly W+1 cycles end to end.
  always_comb begin
    nx_ph    = ph_q;
    nx_k     = k_q;
    nx_x     = mm_res;
    nx_y     = mm_res;
    seq_done = 1'b0;
    if (seq_init_q) begin
      nx_x = a_q;
      if (op_q == OP_MUL) begin
        nx_ph = PH_MUL1;
        nx_y  = b_q;
      end else begin
        nx_ph = PH_ABAR;
        nx_y  = r2_q;
      end
    end else begin
      case (ph_q)
        PH_MUL1: begin nx_ph = PH_MUL2; nx_y = r2_q; end
        PH_ABAR: begin nx_ph = PH_ACC; nx_x = ONE; nx_y = r2_q; end
        PH_ACC:  begin nx_ph = PH_SQ; nx_k = KW'(W-1); end
        PH_SQ, PH_MULB: begin
          if ((ph_q == PH_SQ) && b_q[k_q]) begin
            nx_ph = PH_MULB;
            nx_y  = abar_q;
          end else if (k_q == '0) begin
            nx_ph = PH_FIN;
            nx_y  = ONE;
          end else begin
            nx_ph = PH_SQ;
            nx_k  = k_q - KW'(1);
          end
        end
        default: seq_done = 1'b1;
      endcase
    end
  end

  // Control path: FSM, handshake flags and architecturally visible state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy       <= 1'b0;
      finished   <= 1'b0;
      err        <= 1'b0;
      err_q      <= 1'b0;
      result     <= '0;
      r_valid    <= 1'b0;
      r2_q       <= '0;
      n_r_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      ph_q       <= PH_MUL1;
      seq_init_q <= 1'b0;
    end else begin
      finished <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          busy       <= 1'b1;
          err_q      <= lat_err;
          cnt_q      <= '0;
          seq_init_q <= 1'b1;
          if (lat_err) state_q <= S_DONE;
          else case (control)
            OP_ADD, OP_SUB: state_q <= S_ADDSUB;
            OP_MOD:         state_q <= S_MODRED;
            OP_RSET:        state_q <= S_RSETUP;
            default:        state_q <= S_EXPSEQ;
          endcase
        end
        S_ADDSUB: state_q <= S_DONE;
        S_MODRED, S_RSETUP: begin
          if (cnt_q == CNT_RED_LAST) state_q <= S_DONE;
          else cnt_q <= cnt_q + CW'(1);
        end
        S_EXPSEQ: begin
          seq_init_q <= 1'b0;
          ph_q       <= nx_ph;
          k_q        <= nx_k;
          cnt_q      <= '0;
          state_q    <= seq_done ? S_DONE : S_MONT;
        end
        S_MONT: begin
          if (cnt_q == CNT_MONT_LAST) state_q <= S_EXPSEQ;
          else cnt_q <= cnt_q + CW'(1);
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy     <= 1'b0;
          finished <= 1'b1;
          err      <= err_q;
          if (!err_q) begin
            result <= res_q;
            if (op_q == OP_RSET) begin
              r2_q    <= res_q;
              n_r_q   <= n_q;
              r_valid <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data path: operand latches and arithmetic working registers
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (accept) begin
        op_q  <= control;
        a_q   <= a;
        b_q   <= b;
        n_q   <= modulant;
        sr_q  <= {a, b};
        // RSET seeds with 1 mod n (0 when n = 1); MOD seeds with 0
        acc_q <= {{(W-1){1'b0}}, (control == OP_RSET) && (modulant != ONE)};
      end
      S_ADDSUB: res_q <= (op_q == OP_SUB) ? mod_sub(a_q, b_q, n_q)
                                          : red1({1'b0, {1'b0, a_q} + {1'b0, b_q}}, n_q);
      S_MODRED: begin
        if (cnt_q == CNT_RED_LAST) res_q <= acc_q;
        else begin
          acc_q <= red1({1'b0, acc_q, sr_q[2*W-1]}, n_q);
          sr_q  <= sr_q << 1;
        end
      end
      S_RSETUP: begin
        if (cnt_q == CNT_RED_LAST) res_q <= acc_q;
        else acc_q <= red1({1'b0, acc_q, 1'b0}, n_q);
      end
      S_EXPSEQ: begin
        if (!seq_init_q && (ph_q == PH_ABAR)) abar_q <= mm_res;
        if (seq_done) res_q <= mm_res;
        x_q <= nx_x;
        y_q <= nx_y;
        t_q <= '0;
      end
      S_MONT: begin
        t_q <= mont_step(t_q, x_q[0], y_q, n_q);
        x_q <= x_q >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_accel_seq.sv
// Directed testbench for mod_accel_seq at W=8 with hand-computed results.
module tb_mod_accel_seq;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MODR = 3'b010,
                         RSET = 3'b011, MUL = 3'b100, EXP = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] control = '0;
  logic [7:0] a = '0, b = '0, modulant = '0;
  logic [7:0] result;
  logic       finished, busy, err, r_valid;

  int n_checks = 0;
  int n_errors = 0;

  mod_accel_seq #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .control(control),
    .a(a), .b(b), .modulant(modulant), .result(result),
    .finished(finished), .busy(busy), .err(err), .r_valid(r_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after the latch edge, wait for
  // finished and check latency, err flag, result and pulse width.
  task automatic op_expect(input string tag, input logic [2:0] op,
                           input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] in,
                           input int exp_cyc, input logic exp_err, input logic [7:0] exp_res);
    int cyc;
    @(negedge clk);
    control = op; a = ia; b = ib; modulant = in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    control = ~op; a = ~ia; b = ~ib; modulant = in + 8'd2;
    check({tag, "_busy_rise"}, busy, 1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!finished && cyc < 400);
    check({tag, "_finished"}, finished, 1);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_fall"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_pulse_width"}, finished, 0);
  endtask

  initial begin
    int pulses;
    logic [7:0] res_at_pulse;
    int pulse_cyc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_err", err, 0);
    check("rst_r_valid", r_valid, 0);
    @(negedge clk); rst_n = 1'b1;

    op_expect("add_9_7",    ADD,  8'd9,    8'd7,    8'd13, 2,   1'b0, 8'd3);
    op_expect("sub_3_7",    SUB,  8'd3,    8'd7,    8'd13, 2,   1'b0, 8'd9);
    op_expect("add_a_eq_n", ADD,  8'd13,   8'd1,    8'd13, 1,   1'b1, 8'd9);
    op_expect("sub_0_12",   SUB,  8'd0,    8'd12,   8'd13, 2,   1'b0, 8'd1);
    op_expect("add_12_12",  ADD,  8'd12,   8'd12,   8'd13, 2,   1'b0, 8'd11);
    op_expect("mod_1234",   MODR, 8'h12,   8'h34,   8'd13, 18,  1'b0, 8'd6);
    op_expect("mod_ffff",   MODR, 8'hFF,   8'hFF,   8'd13, 18,  1'b0, 8'd2);
    op_expect("mod_n0",     MODR, 8'h12,   8'h34,   8'd0,  1,   1'b1, 8'd2);
    op_expect("mul_no_r2",  MUL,  8'd7,    8'd9,    8'd13, 1,   1'b1, 8'd2);
    check("r_valid_before_rset", r_valid, 0);
    op_expect("rset_13",    RSET, 8'd0,    8'd0,    8'd13, 18,  1'b0, 8'd3);
    check("r_valid_after_rset", r_valid, 1);
    op_expect("mul_7_9",    MUL,  8'd7,    8'd9,    8'd13, 20,  1'b0, 8'd11);
    op_expect("exp_3_5",    EXP,  8'd3,    8'd5,    8'd13, 119, 1'b0, 8'd9);
    op_expect("exp_3_0",    EXP,  8'd3,    8'd0,    8'd13, 101, 1'b0, 8'd1);
    op_expect("exp_2_ff",   EXP,  8'd2,    8'hFF,   8'd13, 173, 1'b0, 8'd8);
    op_expect("mul_n15",    MUL,  8'd7,    8'd9,    8'd15, 1,   1'b1, 8'd8);
    op_expect("rset_even",  RSET, 8'd0,    8'd0,    8'd12, 1,   1'b1, 8'd8);
    check("r_valid_after_even", r_valid, 1);
    op_expect("illegal_op", 3'b110, 8'd1,  8'd1,    8'd13, 1,   1'b1, 8'd8);
    op_expect("rset_11",    RSET, 8'd0,    8'd0,    8'd11, 18,  1'b0, 8'd9);
    op_expect("mul_7_9_n11", MUL, 8'd7,    8'd9,    8'd11, 20,  1'b0, 8'd8);
    op_expect("mul_old_n",  MUL,  8'd7,    8'd9,    8'd13, 1,   1'b1, 8'd8);

    // start pulses while busy must be ignored: exactly one finished pulse
    @(negedge clk);
    control = MODR; a = 8'h12; b = 8'h34; modulant = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; res_at_pulse = '0; pulse_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin control = ADD; a = 8'd1; b = 8'd1; start = 1'b1; end
      if (c == 8) start = 1'b0;
      @(posedge clk); #1;
      if (finished) begin
        pulses++;
        res_at_pulse = result;
        pulse_cyc = c;
      end
    end
    check("busy_ignore_pulses", pulses, 1);
    check("busy_ignore_result", res_at_pulse, 6);
    check("busy_ignore_cycle", pulse_cyc, 18);

    // Reset in the middle of an exponentiation
    @(negedge clk);
    control = EXP; a = 8'd3; b = 8'd5; modulant = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_r_valid", r_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_finished", finished, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (finished) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);

    op_expect("mul_after_rst", MUL, 8'd7,  8'd9,    8'd11, 1,   1'b1, 8'd0);
    op_expect("add_after_rst", ADD, 8'd9,  8'd7,    8'd13, 2,   1'b0, 8'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_accel_seq.md
MOD_ACCEL_SEQ -- requirements
Module: mod_accel_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand, modulus and result width W (legal values W >= 4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only while busy=0.
REQ-005 The block SHALL have port control, input, 3 bits: opcode; 000 ADD, 001 SUB, 010 MOD, 011 RSET, 100 MUL, 101 EXP, others illegal.
REQ-006 The block SHALL have ports a, b and modulant, input, W bits each: operands and modulus n.
REQ-007 The block SHALL have port result, output, W bits: registered result of the last completed operation.
REQ-008 The block SHALL have port finished, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port err, output, 1 bit: completion-with-error flag, valid while finished=1.
REQ-011 The block SHALL have port r_valid, output, 1 bit: R^2 constant is loaded and matches the stored modulus.

Function
REQ-012 The block SHALL latch control, a, b and modulant on the edge where start=1 and busy=0; busy SHALL rise on that same edge.
REQ-013 The block SHALL ignore start while busy=1, and input changes after the latch edge SHALL NOT affect the operation.
REQ-014 On completion, finished SHALL pulse for exactly one cycle, busy SHALL fall on that same edge, and a new start SHALL be accepted on the following edge.
REQ-015 result SHALL update only on finished edges without err, and SHALL hold its value otherwise.
REQ-016 The FSM SHALL use states IDLE, ADDSUB, MODRED, RSETUP, MONT, EXPSEQ and DONE; DONE SHALL always return to IDLE.
REQ-017 ADD SHALL compute (a+b) mod n and SUB SHALL compute (a-b) mod n, using a W+1-bit intermediate; finished SHALL assert 2 cycles after the latch edge.
REQ-018 MOD SHALL compute the 2W-bit value {a,b} mod n by 2W shift-subtract steps; finished SHALL assert 2W+2 cycles after the latch edge.
REQ-019 RSET SHALL compute R2 = 2^(2W) mod n by 2W modular doublings starting from 1, store R2 and n_r = n, and set r_valid; finished SHALL assert 2W+2 cycles after the latch edge; result SHALL be R2.
REQ-020 Each Montgomery product MM(x,y) = x*y*2^-W mod n SHALL take W+1 cycles: W radix-2 iterations plus one conditional final subtract.
REQ-021 MUL SHALL compute MM(MM(a,b), R2) = a*b mod n; finished SHALL assert 2W+4 cycles after the latch edge.
REQ-022 EXP SHALL compute a^b mod n with MSB-first square-and-multiply over all W bits of b.
REQ-023 The EXP sequence SHALL be: abar = MM(a,R2), acc = MM(1,R2), per bit square then multiply-if-set, then final MM(acc,1).
REQ-024 EXP SHALL take (W + popcount(b) + 3)*(W+1) + 2 cycles from the latch edge to finished.
REQ-025 EXP with b = 0 SHALL return 1 mod n.
REQ-026 Error checks SHALL apply at the latch edge: err=1 and finished SHALL assert 1 cycle later, without touching result or R2.
REQ-027 The error conditions SHALL be: n = 0 (any opcode); ADD/SUB with a >= n or b >= n; RSET/MUL/EXP with even n; MUL/EXP with r_valid=0 or n != n_r; illegal opcode.
REQ-028 A successful RSET with a new modulus SHALL replace R2 and n_r; r_valid SHALL otherwise stay set until reset.
REQ-029 Intermediate values SHALL never exceed W+2 bits, and all arithmetic results SHALL be fully reduced (< n).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE with busy=0, finished=0, err=0, result=0, r_valid=0, R2=0 and n_r=0, including mid-operation; the aborted operation SHALL produce no finished pulse.
REQ-031 After rst_n deasserts, the first start SHALL be sampled on the first rising edge with rst_n=1.

Verification (W=8, n=13 unless stated)
REQ-032 ADD a=9,b=7 -> result=3, finished 2 cycles after the latch edge; SUB a=3,b=7 -> result=9; ADD a=13 -> err=1 one cycle after the latch edge, result unchanged.
REQ-033 MOD a=0x12,b=0x34 -> result=6 at 18 cycles; RSET -> result=3, r_valid=1 at 18 cycles.
REQ-034 MUL before any RSET -> err=1; after RSET, MUL a=7,b=9 -> result=11 at 20 cycles; EXP a=3,b=5 -> result=9 at 119 cycles; EXP b=0 -> result=1.
REQ-035 MUL with n=15 after an RSET at n=13 -> err=1 (modulus mismatch); RSET with n=12 -> err=1 (even modulus), r_valid unchanged.
REQ-036 start pulsed during busy -> ignored, single finished pulse; rst_n low mid-EXP -> busy=0, r_valid=0, result=0, no finished pulse.
